jtag_drv: RTL
=============

Name: jtag_drv

Overview:
- Host-side JTAG initiator: drives TCK/TMS/TDI and samples TDO, so the test bench or FPGA harness can scan IR/DR registers of the chip's TAP controller.
- Accepts scan commands over a valid/ready interface and walks the IEEE 1149.1 TAP state machine.
- Returns captured TDO bits over a one-cycle response strobe.
- Sits between the harness command logic and the chip pins HGO_TCK/HGO_TMS/HGO_TDI/HGO_TDO.

Parameters:
- MAX_LEN, 80, maximum scan length in bits (covers the 80-bit RNG seed/state DR).
- CLK_DIV, 2, clk cycles per TCK half-period; legal range ≥1.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high when idle and able to accept a command.
- i_cmd_op  in  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=idle clocks.
- i_cmd_len  in  LEN_W  bit count for ops 0/1, or TCK count for op 3.
- i_cmd_dat  in  MAX_LEN  TDI data, shifted LSB first.
- o_rsp_valid  out  1  one-cycle pulse when a command completes.
- o_rsp_dat  out  MAX_LEN  captured TDO bits.
- o_tck  out  1  JTAG TCK.
- o_tms  out  1  JTAG TMS.
- o_tdi  out  1  JTAG TDI.
- i_tdo  in  1  JTAG TDO.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: o_tck=0, o_tms=1, o_tdi=0, o_cmd_ready=1, o_rsp_valid=0, o_rsp_dat=0, FSM=IDLE.
- TCK generation:
  - Each TCK period is 2*CLK_DIV clk cycles; a phase counter runs 0..2*CLK_DIV-1.
  - phase 0: o_tck 1→0, and o_tms/o_tdi update to the values for this TCK.
  - phase CLK_DIV: o_tck 0→1, and i_tdo is registered on that same clk edge.
  - o_tck stays low while IDLE.
- Handshake:
  - A command is accepted when i_cmd_valid && o_cmd_ready.
  - o_cmd_ready drops the next cycle and returns to 1 on the cycle after the o_rsp_valid pulse.
  - op/len/dat are latched at accept; input changes while busy are ignored.
- The TAP is assumed to be in Run-Test/Idle (RTI) at command start; every command ends in RTI.
- FSM states: IDLE, HDR, SHIFT, TRL, DONE.
  - HDR TMS sequence: DR = 1,0,0 (Select-DR, Capture-DR, Shift-DR); IR = 1,1,0,0. Reset op = 1,1,1,1,1,0 (6 TCKs, TDI=0); it goes straight to DONE.
  - SHIFT: len TCKs. o_tdi = dat[i] for bit i. TMS=0 for bits 0..len-2 and TMS=1 on bit len-1 (enter Exit1). The TDO sample at bit i's rising edge is stored into rsp bit i.
  - TRL: TMS=1 (Update), then TMS=0 (RTI); TDI=0.
  - Op 3: len TCKs with TMS=0, TDI=0 (stays in RTI); no HDR/TRL.
  - DONE: after the final TCK high phase completes, o_rsp_valid=1 for one cycle and o_rsp_dat holds the result; then IDLE.
- TCK counts: DR = len+5, IR = len+6, reset = 6, idle = len.
- Latency: accept → o_rsp_valid = TCKcount*2*CLK_DIV + 1 cycles.
- o_rsp_dat: bits [len-1:0] are captured data, upper bits are 0. It holds its value until the next completion. Ops 2/3 return all zeros.
- Boundaries:
  - len=0 on op 0/1/3: no TCK activity; o_rsp_valid fires the cycle after accept with data 0.
  - len>MAX_LEN: clamped to MAX_LEN.
  - len=1: the single shift bit carries TMS=1.
  - Reset mid-command: outputs return immediately to reset values. TAP state is then undefined, and the harness must issue op 2 before further scans.
  - i_cmd_valid during DONE: not accepted, because o_cmd_ready=0.

Test Plan:
- Reset, then op 2 with CLK_DIV=2 → TMS on rising edges = 1,1,1,1,1,0; 6 TCK pulses; o_rsp_valid 25 cycles after accept; data 0; ready high the cycle after.
- Op 1 (IR), len=4, dat=4'hA, TAP model → TMS = 1,1,0,0,0,0,0,1,1,0; TDI during shift = 0,1,0,1; o_rsp_dat = 4'b0001 (IR capture pattern); 10 TCKs.
- Op 0 (DR), len=80, dat=80'h0123_4567_89AB_CDEF_1357 into an 80-bit loopback DR preloaded with 80'hFFFF_0000_AAAA_5555_C3C3 → o_rsp_dat = preload value; DR updated to dat; 85 TCKs.
- Op 0 with len=1, dat=1 → a single shift TCK with TMS=1, TDI=1; 6 TCKs total.
- Op 0 with len=0 → no o_tck edges; o_rsp_valid the cycle after accept; o_rsp_dat=0.
- Op 3, len=7 → 7 TCKs with TMS=0, TDI=0. Separately, assert rst_n low at shift bit 40 of an 80-bit DR scan → same cycle o_tck=0, o_tms=1, o_cmd_ready=1; no o_rsp_valid.

Source files
------------

// File: rtl/jtag_drv.sv
// Host-side JTAG initiator: walks the TAP from Run-Test/Idle through IR/DR scans,
// TAP reset or idle clocking, and returns the TDO bits captured during the scan.
`timescale 1ns/1ps
module jtag_drv #(
  parameter int MAX_LEN = 80,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [LEN_W-1:0]   i_cmd_len,
  input  logic [MAX_LEN-1:0] i_cmd_dat,
  output logic               o_rsp_valid,
  output logic [MAX_LEN-1:0] o_rsp_dat,
  output logic               o_tck,
  output logic               o_tms,
  output logic               o_tdi,
  input  logic               i_tdo
);

  localparam int PH_W  = (2*CLK_DIV > 2) ? $clog2(2*CLK_DIV) : 1;
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  localparam logic [PH_W-1:0]  PH_RISE = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2*CLK_DIV-1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  localparam logic [1:0] OP_DR  = 2'd0;
  localparam logic [1:0] OP_IR  = 2'd1;
  localparam logic [1:0] OP_RST = 2'd2;
  localparam logic [1:0] OP_RUN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_TRL,
    ST_DONE
  } state_t;

  state_t             state_reg;
  logic [1:0]         op_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [PH_W-1:0]    phase_reg;
  logic [7:0]         hdr_pat_reg;
  logic [2:0]         hdr_last_reg;
  logic [MAX_LEN-1:0] dat_reg;
  logic [MAX_LEN-1:0] cap_reg;
  logic [MAX_LEN-1:0] mask_reg;

  logic [LEN_W-1:0] len_in;
  logic             len_zero;
  logic             last_bit;
  logic             capture_en;
  logic             bit_tms;
  logic             bit_tdi;

  assign len_in     = (i_cmd_len > LEN_MAX) ? LEN_MAX : i_cmd_len;
  assign len_zero   = (i_cmd_len == '0);
  assign last_bit   = (cnt_reg == (CNT_W'(len_reg) - CNT_W'(1)));
  assign capture_en = (state_reg == ST_SHIFT) && (op_reg != OP_RUN);

  // TMS/TDI to present for the TCK that starts at the next phase 0
  always_comb begin
    bit_tms = 1'b0;
    bit_tdi = 1'b0;
    case (state_reg)
      ST_HDR:   bit_tms = hdr_pat_reg[cnt_reg[2:0]];
      ST_SHIFT: begin
        if (op_reg != OP_RUN) begin
          bit_tms = last_bit;
          bit_tdi = dat_reg[0];
        end
      end
      ST_TRL:   bit_tms = (cnt_reg == '0);
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_DR;
      len_reg      <= '0;
      cnt_reg      <= '0;
      phase_reg    <= '0;
      hdr_pat_reg  <= '0;
      hdr_last_reg <= '0;
      dat_reg      <= '0;
      cap_reg      <= '0;
      mask_reg     <= '0;
      o_tck        <= 1'b0;
      o_tms        <= 1'b1;
      o_tdi        <= 1'b0;
      o_cmd_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_dat    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready  <= 1'b0;
            op_reg       <= i_cmd_op;
            len_reg      <= len_in;
            dat_reg      <= i_cmd_dat;
            cap_reg      <= '0;
            mask_reg     <= MAX_LEN'(1);
            cnt_reg      <= '0;
            phase_reg    <= '0;
            hdr_pat_reg  <= 8'b0000_0001;
            hdr_last_reg <= 3'd2;
            case (i_cmd_op)
              OP_DR: state_reg <= len_zero ? ST_DONE : ST_HDR;
              OP_IR: begin
                hdr_pat_reg  <= 8'b0000_0011;
                hdr_last_reg <= 3'd3;
                state_reg    <= len_zero ? ST_DONE : ST_HDR;
              end
              OP_RST: begin
                // five TMS=1 reach Test-Logic-Reset from anywhere, then one 0 to RTI
                hdr_pat_reg  <= 8'b0001_1111;
                hdr_last_reg <= 3'd5;
                state_reg    <= ST_HDR;
              end
              default: state_reg <= len_zero ? ST_DONE : ST_SHIFT;
            endcase
          end
        end

        ST_HDR, ST_SHIFT, ST_TRL: begin
          phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
          if (phase_reg == '0) begin
            o_tck <= 1'b0;
            o_tms <= bit_tms;
            o_tdi <= bit_tdi;
          end
          if (phase_reg == PH_RISE) begin
            o_tck <= 1'b1;
            if (capture_en && i_tdo) begin
              cap_reg <= cap_reg | mask_reg;
            end
          end
          // segment bookkeeping happens once the TCK high phase is over
          if (phase_reg == PH_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
            case (state_reg)
              ST_HDR: begin
                if (cnt_reg[2:0] == hdr_last_reg) begin
                  cnt_reg   <= '0;
                  state_reg <= (op_reg == OP_RST) ? ST_DONE : ST_SHIFT;
                end
              end
              ST_SHIFT: begin
                dat_reg  <= dat_reg >> 1;
                mask_reg <= mask_reg << 1;
                if (last_bit) begin
                  cnt_reg   <= '0;
                  state_reg <= (op_reg == OP_RUN) ? ST_DONE : ST_TRL;
                end
              end
              default: begin
                if (cnt_reg[0]) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_DONE;
                end
              end
            endcase
          end
        end

        ST_DONE: begin
          phase_reg <= '0;
          o_tck     <= 1'b0;
          if (!o_rsp_valid) begin
            o_rsp_valid <= 1'b1;
            o_rsp_dat   <= cap_reg;
          end else begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
